// File: rtl/ahbl_uart_rx.sv
// ahbl_uart_rx: AHB-Lite slave UART receiver (8N1, 16x oversampling) with a receive FIFO.
//
// Registers (word addressed by HADDR[3:2]):
//   0x0 DATA     RO  [7:0] FIFO head; a read pops the FIFO when it is not empty
//   0x4 STATUS       bit0 not_empty, bit1 full, bit2 overrun (W1C), bit3 frame_err (W1C),
//                    bit4 parity_err (W1C), [11:8] FIFO count
//   0x8 PRESCALE RW  oversample tick every PRESCALE+1 HCLK cycles
//   0xC CTRL     RW  bit0 rx_en, bit1 irq_en, bit2 parity_on, bit3 odd parity
//
// Optional feature macro UART_RX_PARITY_EN: adds the parity bit (CTRL[3:2], STATUS[4]).
// Without it those bits read 0 and no parity state exists.
//
// Ports:
//   HCLK, HRESETn       clock and asynchronous active-low reset
//   HADDR..HWDATA       AHB-Lite slave inputs (HSIZE ignored, word accesses only)
//   HREADYOUT, HRDATA   AHB-Lite slave outputs (no wait states)
//   rx                  serial input, idles high
//   irq                 level interrupt, registered
module ahbl_uart_rx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_RX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  logic unused_bus;
  assign unused_bus = ^{HSIZE, HADDR, HWDATA};
  assign HREADYOUT  = 1'b1;

  // Bus address/data phase tracking.
  logic       valid;
  logic [1:0] addr_q;
  logic       rd_q, wr_q;
  assign valid = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= 2'd0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      if (valid) addr_q <= HADDR[3:2];
      rd_q <= valid & ~HWRITE;
      wr_q <= valid & HWRITE;
    end
  end

  logic wr_status, wr_presc, wr_ctrl;
  assign wr_status = wr_q & (addr_q == 2'd1);
  assign wr_presc  = wr_q & (addr_q == 2'd2);
  assign wr_ctrl   = wr_q & (addr_q == 2'd3);

  // Input synchronizer, resets to the idle level.
  logic [1:0] sync_q;
  logic       rx_sync;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end
  assign rx_sync = sync_q[1];

  // Control / status registers.
  logic [PRESCALE_W-1:0] prescale_q, presc_cnt_q;
  logic                  rx_en_q, irq_en_q, ovr_q, frm_q, irq_q;
  logic                  par_err, par_on, par_odd;
  logic                  tick, presc_clr, push_req, frame_set;
  logic                  not_empty, full, push, pop;

`ifdef UART_RX_PARITY_EN
  logic par_on_q, par_odd_q, par_err_q, par_set, par_bad_q, par_bad_d;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      par_on_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        par_on_q  <= HWDATA[2];
        par_odd_q <= HWDATA[3];
      end
      par_err_q <= par_set | (par_err_q & ~(wr_status & HWDATA[4]));
      par_bad_q <= par_bad_d;
    end
  end
  assign par_err = par_err_q;
  assign par_on  = par_on_q;
  assign par_odd = par_odd_q;
`else
  assign par_err = 1'b0;
  assign par_on  = 1'b0;
  assign par_odd = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale_q <= '0;
      rx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_presc) prescale_q <= HWDATA[PRESCALE_W-1:0];
      if (wr_ctrl) begin
        rx_en_q  <= HWDATA[0];
        irq_en_q <= HWDATA[1];
      end
      // Set has priority over a W1C in the same cycle.
      ovr_q <= (push_req & full) | (ovr_q & ~(wr_status & HWDATA[2]));
      frm_q <= frame_set | (frm_q & ~(wr_status & HWDATA[3]));
      irq_q <= irq_en_q & (not_empty | ovr_q | frm_q | par_err);
    end
  end
  assign irq = irq_q;

  // Oversample prescaler; restarted on a start edge so bit sampling is phase-aligned.
  assign tick = rx_en_q & (presc_cnt_q == prescale_q);
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                             presc_cnt_q <= '0;
    else if (!rx_en_q || presc_clr || tick)   presc_cnt_q <= '0;
    else                                      presc_cnt_q <= presc_cnt_q + PRESCALE_W'(1);
  end

  // Receive FSM.
  state_e     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    presc_clr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    par_set    = 1'b0;
`endif
    if (!rx_en_q) begin
      state_d    = StIdle;
      tick_cnt_d = 4'd0;
      bit_cnt_d  = 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rx_sync) begin
            state_d    = StStart;
            tick_cnt_d = 4'd0;
            presc_clr  = 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            if (tick_cnt_q == 4'd7) begin
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 3'd0;
              state_d    = rx_sync ? StIdle : StData;
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end
        end
        StData: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd15) begin
              shift_d   = {rx_sync, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
                state_d   = par_on ? StParity : StStop;
`else
                state_d   = StStop;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd15) begin
              // Mismatch when data ones plus parity bit do not have the selected parity.
              par_bad_d = (^shift_q) ^ rx_sync ^ par_odd;
              par_set   = par_bad_d;
              state_d   = StStop;
            end
          end
        end
`endif
        StStop: begin
          if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd15) begin
              state_d = StIdle;
              if (!rx_sync) frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
              else          push_req  = ~par_bad_q;
`else
              else          push_req  = 1'b1;
`endif
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Receive FIFO; fullness is judged before a same-cycle pop.
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [4:0]      count_ext;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign push      = push_req & ~full;
  assign pop       = rd_q & (addr_q == 2'd0) & not_empty;
  assign count_ext = 5'(count_q);

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Read data mux, only driven during a read data phase.
  always_comb begin
    HRDATA = 32'd0;
    if (rd_q) begin
      case (addr_q)
        2'd0: HRDATA[7:0] = not_empty ? mem_q[rptr_q] : 8'd0;
        2'd1: HRDATA[11:0] = {count_ext[3:0], 3'd0, par_err, frm_q, ovr_q, full, not_empty};
        2'd2: HRDATA[PRESCALE_W-1:0] = prescale_q;
        default: HRDATA[3:0] = {par_odd, par_on, irq_en_q, rx_en_q};
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Self-checking bench for ahbl_uart_rx: directed sequence with random bytes and prescalers,
// checked against a queue-based model of the receiver's visible behaviour.
module tb_ahbl_uart_rx;

  localparam int unsigned Depth = 8;
  localparam logic [31:0] ADat = 32'h0, ASta = 32'h4, APre = 32'h8, ACtl = 32'hC;
`ifdef UART_RX_PARITY_EN
  localparam logic [31:0] CtrlMask = 32'hF;
`else
  localparam logic [31:0] CtrlMask = 32'h3;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn, HWRITE, HREADY, HSEL, HREADYOUT, rx, irq;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  int checks = 0;
  int errors = 0;
  int bit_cyc = 16;
  logic [31:0] rd, rd2;
  logic [7:0]  d, head;

  // Reference model state.
  logic [7:0] m_fifo[$];
  logic       m_ovr = 1'b0, m_frm = 1'b0, m_par = 1'b0;

  ahbl_uart_rx dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .rx        (rx),
    .irq       (irq)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] v);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = v;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] v);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    v = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic has_par,
                            input logic par_bit);
    logic [10:0] bits;
    int n;
    if (has_par) begin bits = {stop_bit, par_bit, b, 1'b0}; n = 11; end
    else         begin bits = {1'b0, stop_bit, b, 1'b0};    n = 10; end
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (bit_cyc) @(posedge HCLK);
      #1;
    end
    rx = 1'b1;
  endtask

  function automatic logic par_ok(input logic [7:0] b, input logic p, input logic odd);
    return ((($countones(b) + int'(p)) % 2) == (odd ? 1 : 0));
  endfunction

  task automatic model_rx(input logic [7:0] b, input logic stop_ok, input logic p_ok);
    if (!p_ok) m_par = 1'b1;
    if (!stop_ok) m_frm = 1'b1;
    if (stop_ok && p_ok) begin
      if (m_fifo.size() == Depth) m_ovr = 1'b1;
      else                        m_fifo.push_back(b);
    end
  endtask

  function automatic logic [31:0] model_pop();
    if (m_fifo.size() == 0) return 32'd0;
    return {24'd0, m_fifo.pop_front()};
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = m_fifo.size();
    s = 32'd0;
    s[0] = (n != 0);
    s[1] = (n == Depth);
    s[2] = m_ovr;
    s[3] = m_frm;
    s[4] = m_par;
    s[11:8] = n[3:0];
    return s;
  endfunction

  task automatic rx_byte(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0, 1'b0);
    model_rx(b, 1'b1, 1'b1);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      ahb_read(ADat, rd);
      check(tag, rd, model_pop());
    end
  endtask

  initial begin
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0; HWDATA = 32'd0;
    HREADY = 1'b1; HSIZE = 3'b010; rx = 1'b1; HRESETn = 1'b0;
    idle(3);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    HRESETn = 1'b1;
    idle(1);
    ahb_read(ASta, rd); check("rst_status", rd, 32'd0);
    ahb_read(APre, rd); check("rst_prescale", rd, 32'd0);
    ahb_read(ACtl, rd); check("rst_ctrl", rd, 32'd0);
    ahb_write(ACtl, 32'hF);
    ahb_read(ACtl, rd); check("ctrl_mask", rd, CtrlMask);
    ahb_read(ADat, rd); check("empty_read", rd, 32'd0);
    ahb_read(ASta, rd); check("empty_read_no_pop", rd, 32'd0);

    // Basic receive.
    ahb_write(APre, 32'd0);
    ahb_write(ACtl, 32'h1);
    rx_byte(8'hA5);
    ahb_read(ASta, rd); check("basic_status", rd, 32'h101);
    ahb_read(ADat, rd); check("basic_data", rd, model_pop());
    ahb_read(ASta, rd); check("basic_status_after", rd, 32'h000);

    // Random bytes at random prescalers.
    for (int k = 0; k < 6; k++) begin
      rd2 = 32'($urandom_range(0, 3));
      ahb_write(APre, rd2);
      ahb_read(APre, rd); check("prescale_rb", rd, rd2);
      bit_cyc = 16 * (int'(rd2) + 1);
      d = 8'($urandom);
      rx_byte(d);
      ahb_read(ASta, rd); check("rand_status", rd, exp_status());
      ahb_read(ADat, rd); check("rand_data", rd, model_pop());
    end
    ahb_write(APre, 32'd0);
    bit_cyc = 16;

    // FIFO fill and overrun.
    for (int k = 1; k <= 9; k++) rx_byte(8'(k));
    ahb_read(ASta, rd); check("ovr_status", rd, exp_status());
    check("ovr_status_const", rd, 32'h807);
    drain("ovr_data", 8);
    ahb_read(ASta, rd); check("ovr_after_drain", rd, exp_status());
    ahb_write(ASta, 32'h4); m_ovr = 1'b0;
    ahb_read(ASta, rd); check("ovr_w1c", rd, 32'h0);

    // Framing error and interrupt enable.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    model_rx(8'h3C, 1'b0, 1'b1);
    idle(40);
    ahb_read(ASta, rd); check("frame_status", rd, exp_status());
    check("frame_irq_off", {31'd0, irq}, 32'd0);
    ahb_write(ACtl, 32'h3);
    idle(2);
    check("frame_irq_on", {31'd0, irq}, 32'd1);
    ahb_write(ASta, 32'h8); m_frm = 1'b0;
    idle(2);
    check("frame_irq_clr", {31'd0, irq}, 32'd0);
    rx_byte(8'($urandom));
    idle(2);
    check("data_irq", {31'd0, irq}, 32'd1);
    ahb_read(ADat, rd); check("data_irq_read", rd, model_pop());
    idle(2);
    check("data_irq_clr", {31'd0, irq}, 32'd0);
    ahb_write(ACtl, 32'h1);

    // False start then a valid byte.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    ahb_read(ASta, rd); check("false_start_status", rd, 32'h0);
    rx_byte(8'h55);
    ahb_read(ADat, rd); check("after_false_start", rd, model_pop());

    // Pop coinciding with a push at count 3 (push lands 155 cycles after the start edge).
    for (int k = 0; k < 3; k++) rx_byte(8'($urandom));
    d = 8'($urandom);
    head = m_fifo[0];
    fork
      send_frame(d, 1'b1, 1'b0, 1'b0);
      begin
        idle(153);
        ahb_read(ADat, rd2);
      end
    join
    check("pp_head", rd2, {24'd0, head});
    void'(model_pop());
    model_rx(d, 1'b1, 1'b1);
    ahb_read(ASta, rd); check("pp_status", rd, exp_status());
    check("pp_status_const", rd, 32'h301);
    drain("pp_order", 3);

    // Pop coinciding with a push while full: the push is still dropped.
    for (int k = 0; k < 8; k++) rx_byte(8'($urandom));
    d = 8'($urandom);
    head = m_fifo[0];
    fork
      send_frame(d, 1'b1, 1'b0, 1'b0);
      begin
        idle(153);
        ahb_read(ADat, rd2);
      end
    join
    check("ppf_head", rd2, {24'd0, head});
    model_rx(d, 1'b1, 1'b1);
    void'(model_pop());
    ahb_read(ASta, rd); check("ppf_status", rd, exp_status());
    check("ppf_status_const", rd, 32'h705);
    drain("ppf_order", 7);
    ahb_write(ASta, 32'h4); m_ovr = 1'b0;

    // Reset in the middle of a frame.
    ahb_write(APre, 32'd5);
    ahb_write(ACtl, 32'h3);
    bit_cyc = 96;
    rx_byte(8'($urandom));
    idle(2);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    rx = 1'b0;
    idle(50);
    HRESETn = 1'b0;
    #1;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_hrdata", HRDATA, 32'd0);
    check("midrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    rx = 1'b1;
    idle(2);
    HRESETn = 1'b1;
    idle(1);
    m_fifo.delete(); m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
    bit_cyc = 16;
    ahb_read(ASta, rd); check("midrst_status", rd, exp_status());
    ahb_read(APre, rd); check("midrst_prescale", rd, 32'd0);
    ahb_read(ACtl, rd); check("midrst_ctrl", rd, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity.
    ahb_write(ACtl, 32'h5);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    model_rx(8'h07, 1'b1, par_ok(8'h07, 1'b0, 1'b0));
    ahb_read(ASta, rd); check("par_bad_status", rd, exp_status());
    check("par_bad_const", rd, 32'h010);
    ahb_write(ASta, 32'h10); m_par = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    model_rx(8'h07, 1'b1, par_ok(8'h07, 1'b1, 1'b0));
    ahb_read(ASta, rd); check("par_ok_status", rd, 32'h101);
    ahb_read(ADat, rd); check("par_ok_data", rd, model_pop());
    // Odd parity, random bytes and parity bits.
    ahb_write(ACtl, 32'hD);
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      rd2 = 32'($urandom_range(0, 1));
      send_frame(d, 1'b1, 1'b1, rd2[0]);
      model_rx(d, 1'b1, par_ok(d, rd2[0], 1'b1));
      ahb_read(ASta, rd); check("par_odd_status", rd, exp_status());
      ahb_read(ADat, rd); check("par_odd_data", rd, model_pop());
      ahb_write(ASta, 32'h10); m_par = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
